hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the BEAN-2 RV32I core. It keeps a shadow scoreboard of destination registers in flight through Execute, Memory and Write Back, and drives the stall and flush strobes of every pipeline register, including the control pipeline. Three events are resolved with a fixed priority: control-flow redirects, multi-cycle data-memory accesses, and register read-after-write hazards. It sits beside the control logic and consumes its decode and Memory-stage outputs.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for a data-memory access before forced completion; range 1–255.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- rs1_D  in  5  Decode rs1 field
- rs2_D  in  5  Decode rs2 field
- rd_D  in  5  Decode rd field
- reg_RD_D  in  2  Decode read usage: 00 none, 01 rs1, 10 rs2, 11 both
- reg_WE_D  in  1  Decode instruction writes rd
- is_load_D  in  1  Decode opcode 0000011
- is_store_D  in  1  Decode opcode 0100011
- pc_SEL  in  2  Memory-stage PC select; nonzero = redirect
- dmem_ack  in  1  data memory completes the current access this cycle
- dmem_req  out  1  Memory stage holds a valid load/store
- stall_F, stall_D, stall_E, stall_M, stall_WB  out  1 each  hold stage register
- flush_D, flush_E, flush_M, flush_WB  out  1 each  load bubble into stage register at next edge
- mem_timeout  out  1  sticky error, set on forced completion

## Operation
- Scoreboard per stage S in {E, M, WB}: valid_S, rd_S, we_S, ld_S, st_S. It advances with the same stall/flush it drives. A flushed stage loads valid=0. A stalled stage holds.
- A producer counts as live only when valid & we & rd≠0. x0 never causes a hazard.
- Match: (reg_RD_D[0] & rs1_D==rd_S) | (reg_RD_D[1] & rs2_D==rd_S).
- Priority: reset > redirect > memory wait > data hazard.
- Redirect (pc_SEL≠0):
  - flush_D, flush_E and flush_M are asserted.
  - All stalls are 0.
  - A data hazard in the same cycle is ignored.
- Memory FSM: states M_IDLE and M_WAIT.
  - dmem_req = valid_M & (ld_M|st_M).
  - M_IDLE, dmem_req & ~dmem_ack: go to M_WAIT and clear the counter. Assert stall_F/D/E/M and flush_WB.
  - M_WAIT, ~dmem_ack: hold the stalls and increment the counter. When the counter reaches MEM_TIMEOUT-1, force completion, set mem_timeout and return to M_IDLE.
  - M_WAIT, dmem_ack: return to M_IDLE with no stall that cycle.
  - dmem_req & dmem_ack in M_IDLE: zero-wait access, no stall.
- Data hazard: see Configuration. On a stall, stall_F and stall_D are asserted and flush_E inserts a bubble. M and WB advance.
- stall_WB and flush_WB are asserted only as stated above; otherwise they are 0.
- If no event is active, every output is 0.

## Timing
- Reset value of all outputs and scoreboard fields: 0, FSM in M_IDLE, counter 0.
- mem_timeout is cleared only by reset.
- Stall and flush outputs are combinational from scoreboard flops, FSM state, pc_SEL and the Decode inputs.
- They are valid before the next rising edge and are held for whole cycles; flush is glitch-free at cycle level.
- Redirect costs 3 bubbles.
- Load-use costs 1 cycle (forwarding build).
- A memory access costs N stall cycles for an ack N cycles after entry, capped at MEM_TIMEOUT.
- Reset asserted mid-wait or mid-stall returns to the reset state immediately. No pending stall survives.

## Configuration
- HAZARD_FORWARD_EN defined:
  - The forwarding network is present.
  - Only load-use stalls: a live producer in E with ld_E that matches.
  - This costs exactly 1 stall cycle.
- HAZARD_FORWARD_EN undefined:
  - Stall while any live producer in E, M or WB matches.
  - The register file is not write-through, so a dependent instruction stalls up to 3 cycles.

## Test plan
- Forwarding build, lw x5 followed immediately by add x6,x5,x1: exactly one cycle with stall_F=stall_D=flush_E=1. The add enters E on the next cycle.
- Non-forwarding build, addi x5 then add x6,x5,x5: 3 consecutive stall cycles. Same sequence with rd=x0: 0 stall cycles.
- Taken branch reaches M (pc_SEL=11) while a load-use hazard is in D: flush_D/E/M=1, all stalls 0 for that cycle.
- Load in M with dmem_ack arriving 4 cycles after entry: 4 cycles of stall_F/D/E/M=1 with flush_WB=1. dmem_req stays high.
- dmem_ack held low with MEM_TIMEOUT=16: forced completion after 16 stall cycles, mem_timeout=1 and sticky. A reset pulse clears it and all outputs read 0.
- Reset asserted during M_WAIT: all outputs 0 asynchronously. After release the pipeline restarts with an empty scoreboard.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller: shadow scoreboard for E/M/WB, redirect flush,
// data-memory wait FSM and RAW stalls. Define HAZARD_FORWARD_EN for the forwarding build.
module hazard_controller #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1_D,
   input  logic [4:0] rs2_D,
   input  logic [4:0] rd_D,
   input  logic [1:0] reg_RD_D,
   input  logic       reg_WE_D,
   input  logic       is_load_D,
   input  logic       is_store_D,
   input  logic [1:0] pc_SEL,
   input  logic       dmem_ack,
   output logic       dmem_req,
   output logic       stall_F,
   output logic       stall_D,
   output logic       stall_E,
   output logic       stall_M,
   output logic       stall_WB,
   output logic       flush_D,
   output logic       flush_E,
   output logic       flush_M,
   output logic       flush_WB,
   output logic       mem_timeout
);

   typedef enum logic {M_IDLE, M_WAIT} mstate_t;

   mstate_t    r_state;
   logic [7:0] r_cnt;
   logic       r_timeout;

   logic       r_valid_E, r_we_E, r_ld_E, r_st_E;
   logic [4:0] r_rd_E;
   logic       r_valid_M, r_we_M, r_ld_M, r_st_M;
   logic [4:0] r_rd_M;
   logic       r_valid_WB, r_we_WB;
   logic [4:0] r_rd_WB;

   logic w_match_E, w_match_M, w_match_WB;
   logic w_data_haz, w_req, w_redirect, w_force, w_mem_stall;

   // x0 is never a live producer, so it cannot match
   assign w_match_E  = r_valid_E & r_we_E & (r_rd_E != '0) &
                       ((reg_RD_D[0] & (rs1_D == r_rd_E)) | (reg_RD_D[1] & (rs2_D == r_rd_E)));
   assign w_match_M  = r_valid_M & r_we_M & (r_rd_M != '0) &
                       ((reg_RD_D[0] & (rs1_D == r_rd_M)) | (reg_RD_D[1] & (rs2_D == r_rd_M)));
   assign w_match_WB = r_valid_WB & r_we_WB & (r_rd_WB != '0) &
                       ((reg_RD_D[0] & (rs1_D == r_rd_WB)) | (reg_RD_D[1] & (rs2_D == r_rd_WB)));

`ifdef HAZARD_FORWARD_EN
   assign w_data_haz = w_match_E & r_ld_E;
`else
   assign w_data_haz = w_match_E | w_match_M | w_match_WB;
`endif

   assign w_req       = r_valid_M & (r_ld_M | r_st_M);
   assign w_redirect  = (pc_SEL != 2'b00);
   // Forced completion behaves like an ack: the access leaves M with no stall that cycle
   assign w_force     = (r_state == M_WAIT) & ~dmem_ack & (r_cnt == 8'(MEM_TIMEOUT - 1));
   assign w_mem_stall = w_req & ~dmem_ack & ((r_state == M_IDLE) | ~w_force);

   always_comb begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
      stall_E  = 1'b0;
      stall_M  = 1'b0;
      stall_WB = 1'b0;
      flush_D  = 1'b0;
      flush_E  = 1'b0;
      flush_M  = 1'b0;
      flush_WB = 1'b0;
      if (!reset) begin
         if (w_redirect) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
         end else if (w_mem_stall) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            flush_WB = 1'b1;
         end else if (w_data_haz) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   assign dmem_req    = ~reset & w_req;
   assign mem_timeout = r_timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= M_IDLE;
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
         r_valid_E  <= 1'b0; r_we_E  <= 1'b0; r_ld_E <= 1'b0; r_st_E <= 1'b0; r_rd_E <= '0;
         r_valid_M  <= 1'b0; r_we_M  <= 1'b0; r_ld_M <= 1'b0; r_st_M <= 1'b0; r_rd_M <= '0;
         r_valid_WB <= 1'b0; r_we_WB <= 1'b0; r_rd_WB <= '0;
      end else begin
         if (w_redirect) begin
            r_state <= M_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               M_IDLE: if (w_req && !dmem_ack) begin
                  r_state <= M_WAIT;
                  r_cnt   <= '0;
               end
               M_WAIT: if (dmem_ack || !w_req) begin
                  r_state <= M_IDLE;
               end else if (w_force) begin
                  r_state   <= M_IDLE;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
               default: r_state <= M_IDLE;
            endcase
         end

         if (flush_E) begin
            r_valid_E <= 1'b0;
         end else if (!stall_E) begin
            r_valid_E <= 1'b1;
            r_rd_E    <= rd_D;
            r_we_E    <= reg_WE_D;
            r_ld_E    <= is_load_D;
            r_st_E    <= is_store_D;
         end

         if (flush_M) begin
            r_valid_M <= 1'b0;
         end else if (!stall_M) begin
            r_valid_M <= r_valid_E;
            r_rd_M    <= r_rd_E;
            r_we_M    <= r_we_E;
            r_ld_M    <= r_ld_E;
            r_st_M    <= r_st_E;
         end

         if (flush_WB) begin
            r_valid_WB <= 1'b0;
         end else if (!stall_WB) begin
            r_valid_WB <= r_valid_M;
            r_rd_WB    <= r_rd_M;
            r_we_WB    <= r_we_M;
         end
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: per-cycle expected strobes are queued when
// the Decode/Memory stimulus is driven and checked mid-cycle by a monitor.
module tb_hazard_controller;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [1:0] rduse;
      logic       we;
      logic       ld;
      logic       st;
   } instr_t;

   // {req, sF, sD, sE, sM, sWB, fD, fE, fM, fWB, timeout}
   localparam logic [10:0] NONE  = 11'b000_0000_0000;
   localparam logic [10:0] REQ   = 11'b100_0000_0000;
   localparam logic [10:0] HAZ   = 11'b011_0000_1000;
   localparam logic [10:0] MEMST = 11'b111_1100_0010;
   localparam logic [10:0] REDIR = 11'b000_0001_1100;
   localparam logic [10:0] TO    = 11'b000_0000_0001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs1_D = '0, rs2_D = '0, rd_D = '0;
   logic [1:0] reg_RD_D = '0;
   logic       reg_WE_D = 1'b0, is_load_D = 1'b0, is_store_D = 1'b0;
   logic [1:0] pc_SEL = '0;
   logic       dmem_ack = 1'b0;
   logic       dmem_req, stall_F, stall_D, stall_E, stall_M, stall_WB;
   logic       flush_D, flush_E, flush_M, flush_WB, mem_timeout;
   logic [10:0] outs;

   int n_assert = 0;
   int n_fail   = 0;
   string       tag_q[$];
   logic [10:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_controller #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_RD_D(reg_RD_D),
      .reg_WE_D(reg_WE_D), .is_load_D(is_load_D), .is_store_D(is_store_D),
      .pc_SEL(pc_SEL), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .stall_WB(stall_WB), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
      .flush_WB(flush_WB), .mem_timeout(mem_timeout)
   );

   assign outs = {dmem_req, stall_F, stall_D, stall_E, stall_M, stall_WB,
                  flush_D, flush_E, flush_M, flush_WB, mem_timeout};

   function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [1:0] rduse, input logic we, input logic ld, input logic st);
      instr_t i;
      i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rduse = rduse; i.we = we; i.ld = ld; i.st = st;
      return i;
   endfunction

   task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (req sF sD sE sM sWB fD fE fM fWB to)", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input instr_t i, input logic [1:0] pc, input logic ack,
                       input logic rst, input logic [10:0] exp);
      @(negedge clk);
      reset      = rst;
      rs1_D      = i.rs1;
      rs2_D      = i.rs2;
      rd_D       = i.rd;
      reg_RD_D   = i.rduse;
      reg_WE_D   = i.we;
      is_load_D  = i.ld;
      is_store_D = i.st;
      pc_SEL     = pc;
      dmem_ack   = ack;
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic drain(input int unsigned n);
      for (int unsigned k = 0; k < n; k++)
         step("drain", mk(0, 0, 0, 2'b00, 0, 0, 0), 2'b00, 1'b0, 1'b0, NONE);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() != 0) check_eq(tag_q.pop_front(), outs, exp_q.pop_front());
      end
   end

   initial begin
      instr_t NOP, ADDI5, ADD655, ADDI0, ADD600, LW5, ADD651, LW9, ADD109, LW11, LW12, SW23;
      NOP    = mk(0, 0, 0,  2'b00, 0, 0, 0);
      ADDI5  = mk(1, 0, 5,  2'b01, 1, 0, 0);
      ADD655 = mk(5, 5, 6,  2'b11, 1, 0, 0);
      ADDI0  = mk(1, 0, 0,  2'b01, 1, 0, 0);
      ADD600 = mk(0, 0, 6,  2'b11, 1, 0, 0);
      LW5    = mk(2, 0, 5,  2'b01, 1, 1, 0);
      ADD651 = mk(5, 1, 6,  2'b11, 1, 0, 0);
      LW9    = mk(2, 0, 9,  2'b01, 1, 1, 0);
      ADD109 = mk(9, 0, 10, 2'b01, 1, 0, 0);
      LW11   = mk(2, 0, 11, 2'b01, 1, 1, 0);
      LW12   = mk(2, 0, 12, 2'b01, 1, 1, 0);
      SW23   = mk(2, 3, 0,  2'b11, 0, 0, 1);

      // reset gates even a redirect request
      step("rst_hold", ADD655, 2'b11, 1'b0, 1'b1, NONE);
      step("rst_hold2", ADD655, 2'b11, 1'b1, 1'b1, NONE);
      drain(2);

      // RAW on an ALU producer
      step("A_addi", ADDI5, 2'b00, 1'b0, 1'b0, NONE);
`ifdef HAZARD_FORWARD_EN
      step("A_add_fwd", ADD655, 2'b00, 1'b0, 1'b0, NONE);
      step("A_next", NOP, 2'b00, 1'b0, 1'b0, NONE);
`else
      step("A_raw_E", ADD655, 2'b00, 1'b0, 1'b0, HAZ);
      step("A_raw_M", ADD655, 2'b00, 1'b0, 1'b0, HAZ);
      step("A_raw_WB", ADD655, 2'b00, 1'b0, 1'b0, HAZ);
      step("A_go", ADD655, 2'b00, 1'b0, 1'b0, NONE);
`endif
      drain(3);

      // x0 producer never stalls
      step("B_addi_x0", ADDI0, 2'b00, 1'b0, 1'b0, NONE);
      step("B_use_x0", ADD600, 2'b00, 1'b0, 1'b0, NONE);
      step("B_next", NOP, 2'b00, 1'b0, 1'b0, NONE);
      drain(3);

      // load-use
      step("C_lw", LW5, 2'b00, 1'b0, 1'b0, NONE);
      step("C_lu_E", ADD651, 2'b00, 1'b0, 1'b0, HAZ);
`ifdef HAZARD_FORWARD_EN
      step("C_go_ack", ADD651, 2'b00, 1'b1, 1'b0, REQ);
      step("C_next", NOP, 2'b00, 1'b0, 1'b0, NONE);
`else
      step("C_lu_M_ack", ADD651, 2'b00, 1'b1, 1'b0, REQ | HAZ);
      step("C_lu_WB", ADD651, 2'b00, 1'b0, 1'b0, HAZ);
      step("C_go", ADD651, 2'b00, 1'b0, 1'b0, NONE);
`endif
      drain(3);

      // redirect overrides a load-use hazard; the flushed load never requests memory
      step("D_lw", LW5, 2'b00, 1'b0, 1'b0, NONE);
      step("D_redirect", ADD651, 2'b11, 1'b0, 1'b0, REDIR);
      step("D_after1", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("D_after2", NOP, 2'b00, 1'b0, 1'b0, NONE);
      drain(2);

      // load ack arrives 4 cycles after entering M; memory wait outranks the RAW stall
      step("E_lw", LW9, 2'b00, 1'b0, 1'b0, NONE);
      step("E_nop", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("E_wait0", ADD109, 2'b00, 1'b0, 1'b0, MEMST);
      step("E_wait1", ADD109, 2'b00, 1'b0, 1'b0, MEMST);
      step("E_wait2", ADD109, 2'b00, 1'b0, 1'b0, MEMST);
      step("E_wait3", ADD109, 2'b00, 1'b0, 1'b0, MEMST);
`ifdef HAZARD_FORWARD_EN
      step("E_ack", ADD109, 2'b00, 1'b1, 1'b0, REQ);
      step("E_next", NOP, 2'b00, 1'b0, 1'b0, NONE);
`else
      step("E_ack", ADD109, 2'b00, 1'b1, 1'b0, REQ | HAZ);
      step("E_raw_WB", ADD109, 2'b00, 1'b0, 1'b0, HAZ);
      step("E_go", ADD109, 2'b00, 1'b0, 1'b0, NONE);
`endif
      drain(3);

      // no ack: 16 stall cycles, forced completion, sticky timeout, cleared by reset
      step("F_lw", LW11, 2'b00, 1'b0, 1'b0, NONE);
      step("F_nop", NOP, 2'b00, 1'b0, 1'b0, NONE);
      for (int unsigned k = 0; k < 16; k++)
         step($sformatf("F_wait%0d", k), NOP, 2'b00, 1'b0, 1'b0, MEMST);
      step("F_forced", NOP, 2'b00, 1'b0, 1'b0, REQ);
      step("F_sticky0", NOP, 2'b00, 1'b0, 1'b0, TO);
      step("F_sticky1", NOP, 2'b00, 1'b0, 1'b0, TO);
      step("F_sticky2", NOP, 2'b00, 1'b1, 1'b0, TO);
      step("F_rst", NOP, 2'b10, 1'b0, 1'b1, NONE);
      step("F_after_rst", NOP, 2'b00, 1'b0, 1'b0, NONE);
      drain(2);

      // reset in the middle of a memory wait
      step("G_lw", LW12, 2'b00, 1'b0, 1'b0, NONE);
      step("G_nop", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("G_wait0", NOP, 2'b00, 1'b0, 1'b0, MEMST);
      step("G_wait1", NOP, 2'b00, 1'b0, 1'b0, MEMST);
      step("G_wait2", NOP, 2'b00, 1'b0, 1'b0, MEMST);
      step("G_rst", NOP, 2'b00, 1'b0, 1'b1, NONE);
      step("G_clear0", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("G_clear1", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("G_sw", SW23, 2'b00, 1'b0, 1'b0, NONE);
      step("G_sw_E", NOP, 2'b00, 1'b0, 1'b0, NONE);
      step("G_sw_M_ack", NOP, 2'b00, 1'b1, 1'b0, REQ);
      step("G_end", NOP, 2'b00, 1'b0, 1'b0, NONE);

      @(negedge clk);
      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
